if_stage: RTL and testbench



---
 rtl/if_stage_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 44 ++++
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants and types for the npc instruction-fetch stage.
// Imported by the fetch interface and the fetch stage.
package if_stage_pkg;

    localparam int XLEN     = 64;
    localparam int INST_LEN = 32;

    localparam logic [XLEN-1:0]     RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [INST_LEN-1:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [INST_LEN-1:0] inst;
        logic                misalign;
    } id_entry_t;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and
// the valid/ready handoff to decode.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_rsp_valid;
    logic [INST_LEN-1:0] imem_rsp_data;

    logic                id_valid;
    logic                id_ready;
    logic [XLEN-1:0]     id_pc;
    logic [INST_LEN-1:0] id_inst;
    logic                id_misalign;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output id_valid,
        output id_pc,
        output id_inst,
        output id_misalign,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  id_valid,
        input  id_pc,
        input  id_inst,
        input  id_misalign,
        output id_ready
    );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one imem read in flight
// and hands {pc, inst} to decode; redirects squash stale fetches.
module if_stage
    import if_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    if_stage_if.master      bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e          state;
    state_e          state_nx;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nx;
    id_entry_t       id_q;
    id_entry_t       id_nx;
    logic            id_valid_q;
    logic            id_valid_nx;
    logic            pc_bad;
    logic            rsp;

    assign pc_bad = misaligned(pc);
    assign rsp    = bus.imem_rsp_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    state_nx = S_REQ;
                end else if (pc_bad) begin
                    state_nx = S_HOLD;
                end else if (bus.imem_req_ready) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid && rsp) begin
                    state_nx = S_REQ;
                end else if (redirect_valid) begin
                    state_nx = S_DISCARD;
                end else if (rsp) begin
                    state_nx = S_HOLD;
                end
            end
            S_DISCARD: begin
                if (rsp) begin
                    state_nx = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect_valid || bus.id_ready) begin
                    state_nx = S_REQ;
                end
            end
        endcase
    end

    always_comb begin
        pc_nx       = pc;
        id_nx       = id_q;
        id_valid_nx = id_valid_q;
        unique case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                end else if (pc_bad) begin
                    // Parked on a NOP; the trap is raised downstream.
                    id_nx       = '{pc: pc, inst: NOP, misalign: 1'b1};
                    id_valid_nx = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                end else if (rsp) begin
                    id_nx = '{
                        pc:       pc,
                        inst:     bus.imem_rsp_data,
                        misalign: 1'b0
                    };
                    id_valid_nx = 1'b1;
                    pc_nx       = pc + XLEN'(4);
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    id_valid_nx = 1'b0;
                    pc_nx       = redirect_pc;
                end else if (bus.id_ready) begin
                    id_valid_nx = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            id_valid_q <= 1'b0;
            id_q       <= '{pc: '0, inst: NOP, misalign: 1'b0};
        end else begin
            pc         <= pc_nx;
            id_valid_q <= id_valid_nx;
            id_q       <= id_nx;
        end
    end

    assign bus.imem_req_valid = rst_n && (state == S_REQ)
                                && !pc_bad && !redirect_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_pc          = id_q.pc;
    assign bus.id_inst        = id_q.inst;
    assign bus.id_misalign    = id_q.misalign;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a simple latency-programmable
// instruction memory responder.
module tb_if_stage;
    import if_stage_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    if_stage_if bus ();

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    int          mem_lat  = 1;
    logic [31:0] mem_data = 32'h0050_0093;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Memory: respond mem_lat cycles after an accepted request.
    initial begin
        logic acc;
        logic pend;
        int   cnt;
        pend = 1'b0;
        cnt  = 0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            acc = bus.imem_req_valid && bus.imem_req_ready;
            #1;
            bus.imem_rsp_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (acc) begin
                    pend = 1'b1;
                    cnt  = mem_lat;
                end
                if (pend) begin
                    if (cnt <= 1) begin
                        bus.imem_rsp_valid = 1'b1;
                        bus.imem_rsp_data  = mem_data;
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n              = 1'b0;
        redirect_valid     = 1'b0;
        redirect_pc        = '0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b0;

        cyc();
        cyc();
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_id_pc", bus.id_pc, 64'd0);
        chk("rst_id_inst", 64'(bus.id_inst), 64'h13);
        chk("rst_misalign", 64'(bus.id_misalign), 64'd0);
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);

        // Basic fetch
        rst_n = 1'b1;
        #1;
        chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("first_req_addr", bus.imem_req_addr, 64'h8000_0000);
        cyc();
        chk("wait_no_req", 64'(bus.imem_req_valid), 64'd0);
        chk("wait_no_valid", 64'(bus.id_valid), 64'd0);
        cyc();
        chk("f1_valid", 64'(bus.id_valid), 64'd1);
        chk("f1_pc", bus.id_pc, 64'h8000_0000);
        chk("f1_inst", 64'(bus.id_inst), 64'h0050_0093);
        chk("f1_misalign", 64'(bus.id_misalign), 64'd0);

        // Decode back-pressure
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", 64'(bus.id_valid), 64'd1);
            chk("stall_pc", bus.id_pc, 64'h8000_0000);
            chk("stall_inst", 64'(bus.id_inst), 64'h0050_0093);
            chk("stall_no_req", 64'(bus.imem_req_valid), 64'd0);
        end
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        mem_lat      = 3;
        mem_data     = 32'hDEAD_BEEF;
        #1;
        chk("resume_valid_low", 64'(bus.id_valid), 64'd0);
        chk("resume_req", 64'(bus.imem_req_valid), 64'd1);
        chk("resume_addr", bus.imem_req_addr, 64'h8000_0004);

        // Redirect while waiting; late response must be discarded
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("disc_no_req", 64'(bus.imem_req_valid), 64'd0);
        cyc();
        chk("disc_no_req2", 64'(bus.imem_req_valid), 64'd0);
        cyc();
        mem_lat  = 1;
        mem_data = 32'h00A0_0113;
        chk("disc_dropped", 64'(bus.id_valid), 64'd0);
        chk("disc_req", 64'(bus.imem_req_valid), 64'd1);
        chk("disc_addr", bus.imem_req_addr, 64'h8000_0100);

        // Redirect coincident with the response
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("coinc_dropped", 64'(bus.id_valid), 64'd0);
        chk("coinc_req", 64'(bus.imem_req_valid), 64'd1);
        chk("coinc_addr", bus.imem_req_addr, 64'h8000_0300);
        cyc();
        cyc();
        chk("f2_valid", 64'(bus.id_valid), 64'd1);
        chk("f2_pc", bus.id_pc, 64'h8000_0300);
        chk("f2_inst", 64'(bus.id_inst), 64'h00A0_0113);

        // Redirect beats id_ready in HOLD; target is misaligned
        bus.id_ready   = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        cyc();
        bus.id_ready   = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("redir_drop_valid", 64'(bus.id_valid), 64'd0);
        chk("mis_no_req", 64'(bus.imem_req_valid), 64'd0);
        cyc();
        chk("mis_valid", 64'(bus.id_valid), 64'd1);
        chk("mis_flag", 64'(bus.id_misalign), 64'd1);
        chk("mis_pc", bus.id_pc, 64'h8000_0102);
        chk("mis_inst", 64'(bus.id_inst), 64'h13);
        chk("mis_no_req2", 64'(bus.imem_req_valid), 64'd0);
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        cyc();
        chk("mis_again_valid", 64'(bus.id_valid), 64'd1);
        chk("mis_again_pc", bus.id_pc, 64'h8000_0102);
        mem_data       = 32'h0000_0517;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("fix_req", 64'(bus.imem_req_valid), 64'd1);
        chk("fix_addr", bus.imem_req_addr, 64'h8000_0200);
        cyc();
        cyc();
        chk("f3_valid", 64'(bus.id_valid), 64'd1);
        chk("f3_pc", bus.id_pc, 64'h8000_0200);
        chk("f3_inst", 64'(bus.id_inst), 64'h0000_0517);
        chk("f3_misalign", 64'(bus.id_misalign), 64'd0);

        // Reset while holding
        rst_n = 1'b0;
        cyc();
        chk("mrst_valid", 64'(bus.id_valid), 64'd0);
        chk("mrst_addr", bus.imem_req_addr, 64'h8000_0000);
        chk("mrst_req", 64'(bus.imem_req_valid), 64'd0);
        chk("mrst_inst", 64'(bus.id_inst), 64'h13);
        rst_n = 1'b1;
        #1;
        chk("mrst_req_after", 64'(bus.imem_req_valid), 64'd1);

        // PC wrap
        mem_data       = 32'h0000_0093;
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr0", bus.imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        cyc();
        chk("wrap_pc", bus.id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        bus.id_ready = 1'b1;
        cyc();
        bus.id_ready = 1'b0;
        #1;
        chk("wrap_req", 64'(bus.imem_req_valid), 64'd1);
        chk("wrap_addr", bus.imem_req_addr, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
